// File: rtl/proc_input_cond.sv
// proc_input_cond: synchronizes and debounces the raw board switches and
// push-buttons, presenting stable zero-extended 32-bit words to the
// processor input ports plus single-cycle press/release strobes for the
// buttons. Every input bit is an independent channel (2-flop synchronizer,
// stable register and saturating-free run-length counter).

module proc_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in0_switches,
    input  logic [4:0]  in1_switches,
    input  logic [3:0]  buttons,
    output logic [31:0] proc_in0,
    output logic [31:0] proc_in1,
    output logic [31:0] proc_in2,
    output logic [3:0]  btn_press,
    output logic [3:0]  btn_release
);

    // Channel layout in the flat raw vector: [4:0] bank 0, [9:5] bank 1,
    // [13:10] buttons. Only the button channels carry edge strobes.
    localparam int SW0_BITS = 5;
    localparam int SW1_BITS = 5;
    localparam int BTN_BITS = 4;
    localparam int BTN_BASE = SW0_BITS + SW1_BITS;
    localparam int NUM_CH   = SW0_BITS + SW1_BITS + BTN_BITS;

    // Counter only has to reach DEBOUNCE_CYCLES-1 before it is cleared.
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    logic [NUM_CH-1:0]   raw_vec;
    logic [NUM_CH-1:0]   q_vec;
    logic [BTN_BITS-1:0] press_vec;
    logic [BTN_BITS-1:0] release_vec;

    assign raw_vec = {buttons, in1_switches, in0_switches};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic          s1_reg;
            logic          s2_reg;
            logic          q_reg;
            logic [CW-1:0] cnt_reg;
            logic          differ;
            logic          flip_next;

            // The stable value flips on the edge where the synchronized bit
            // has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
            assign differ    = (s2_reg != q_reg);
            assign flip_next = differ && (cnt_reg == CNT_LAST);

            // Synchronizer, debounce counter and stable value for one bit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    q_reg   <= 1'b0;
                    cnt_reg <= CNT_ZERO;
                end else begin
                    s1_reg <= raw_vec[gi];
                    s2_reg <= s1_reg;
                    if (!differ) begin
                        // Agreement (or a glitch returning) restarts the run.
                        cnt_reg <= CNT_ZERO;
                    end else if (flip_next) begin
                        q_reg   <= s2_reg;
                        cnt_reg <= CNT_ZERO;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign q_vec[gi] = q_reg;

            if (gi >= BTN_BASE) begin : g_btn
                logic press_reg;
                logic release_reg;

                // Strobes are loaded alongside q so they line up with the
                // first cycle in which the new stable value is visible.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        press_reg   <= 1'b0;
                        release_reg <= 1'b0;
                    end else begin
                        press_reg   <= flip_next &  s2_reg;
                        release_reg <= flip_next & ~s2_reg;
                    end
                end

                assign press_vec[gi - BTN_BASE]   = press_reg;
                assign release_vec[gi - BTN_BASE] = release_reg;
            end
        end
    endgenerate

    // Outputs come straight from registers; no raw input reaches them
    // combinationally.
    assign proc_in0    = {27'b0, q_vec[SW0_BITS-1:0]};
    assign proc_in1    = {27'b0, q_vec[SW0_BITS +: SW1_BITS]};
    assign proc_in2    = {28'b0, q_vec[BTN_BASE +: BTN_BITS]};
    assign btn_press   = press_vec;
    assign btn_release = release_vec;

endmodule

// File: doc/proc_input_cond.md
# proc_input_cond

Input conditioning stage that sits directly upstream of the processor's `in0`/`in1`/`in2` ports. It takes the raw board switches (two 5-bit banks) and the 4 push-buttons, synchronizes them into the `clk` domain, and debounces every bit independently. It drives the zero-extended 32-bit processor input words, plus one-cycle press/release pulses for the buttons.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronized bit must differ from its stable value before the stable value flips. Legal range ≥ 1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock; asserting `rst` low immediately clears all state.
- `in0_switches`  in  5  raw switch bank 0; asynchronous to `clk`, may bounce.
- `in1_switches`  in  5  raw switch bank 1; asynchronous, may bounce.
- `buttons`  in  4  raw push-buttons; asynchronous, may bounce.
- `proc_in0`  out  32  `{27'b0, stable in0_switches}`.
- `proc_in1`  out  32  `{27'b0, stable in1_switches}`.
- `proc_in2`  out  32  `{28'b0, stable buttons}`.
- `btn_press`  out  4  1-cycle pulse per button on a stable 0→1 transition.
- `btn_release`  out  4  1-cycle pulse per button on a stable 1→0 transition.

## Operation
- There are 14 identical bit channels (5 + 5 + 4). Each channel holds:
  - 2-flop synchronizer: `s1` ← raw, `s2` ← `s1`.
  - Stable register `q`.
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
- Per channel, each rising edge:
  - If `s2 == q`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `q` ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
- Any glitch on `s2` that returns to `q` before the count completes restarts the count from 0. `q` never flips in that case.
- Button channels only: `btn_press[i]` and `btn_release[i]` are registers, loaded each edge with (`q` about to rise) and (`q` about to fall) respectively. Each pulse is therefore high for exactly the one cycle in which the new `q` is first visible.
- `proc_in*` are direct zero-extensions of the `q` registers. There is no combinational path from raw inputs to any output.
- Channels are fully independent. Simultaneous changes on several bits each complete on their own schedule.
- A press and a release can never pulse together on the same button.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.

## Timing
- Reset values (all registers): `s1`, `s2`, `q`, `cnt` = 0. All outputs therefore reset to 0: `proc_in0`/`1`/`2` = 0, `btn_press` = `btn_release` = 0.
  - Outputs drop to 0 asynchronously when `rst` falls, without waiting for a clock edge.
  - First update on the first rising edge after `rst` rises.
- Latency for a clean step, raw input stable from before edge E1:
  - `s1` at E1, `s2` at E2.
  - `q` and the pulse update at edge E(`DEBOUNCE_CYCLES`+2).
  - Example: `DEBOUNCE_CYCLES`=4 gives a 6-edge latency.
- Pulse width: exactly 1 cycle, deasserted at the next edge unless another transition completes (impossible within `DEBOUNCE_CYCLES` ≥ 1 edges).
- Reset mid-count: the count is discarded. After release, the input is treated as a fresh change relative to `q`=0.
- A raw input already high at reset release reaches `q`=1 after `DEBOUNCE_CYCLES`+2 edges. This produces a `btn_press` pulse for buttons.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `rst`=0 with all raw inputs = 1 for 3 cycles.
  - During reset: all outputs = 0.
  - Release `rst`: `proc_in0`=`proc_in1`=`32'h1f` and `proc_in2`=`32'hf` at the 6th edge; `btn_press`=`4'hf` for that one cycle only.
- **Clean step:** `in0_switches`=`5'b10101` applied before edge 1 → `proc_in0`=`32'h15` first visible after edge 6, not after edge 5.
- **Bounce:** `buttons[2]` toggles 1,0,1,0 on successive cycles, then holds 1.
  - No output change and no pulse during the toggling.
  - `proc_in2`=`32'h4` and `btn_press`=`4'b0100` exactly 6 edges after the final 0→1; `btn_release` stays 0.
- **Release:** from `buttons`=`4'b0001` stable, drop to 0 → `btn_release`=`4'b0001` for one cycle, 6 edges later; `proc_in2`=0.
- **Reset mid-count:** `in1_switches`=`5'b00011` applied, then `rst` pulsed low after 3 edges.
  - Outputs stay 0 throughout.
  - After release, `proc_in1`=`32'h3` at the 6th edge post-reset.
- **Simultaneous channels:** `buttons[0]` rises at cycle 0 and `buttons[3]` at cycle 2 → separate single-cycle `btn_press` pulses (`4'b0001`, then `4'b1000`) 2 cycles apart.
